// File: rtl/sensor_inject_sched.sv
// sensor_inject_sched: frames a recirculating cell stream into AXI-Stream bursts with idle gaps.
// Define SENSOR_INJECT_SCHED_STALL_EN to build the sink-stall cycle counter.
module sensor_inject_sched #(
  parameter int CNT_W = 32,
  parameter int GAP_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_START,
  input  logic             i_START_wstrobe,
  input  logic             i_STOP,
  input  logic             i_STOP_wstrobe,
  input  logic [CNT_W-1:0] i_FRAME_LEN,
  input  logic [CNT_W-1:0] i_FRAME_COUNT,
  input  logic [GAP_W-1:0] i_GAP_CYCLES,
  input  logic [31:0]      i_FIFO_COUNT,
  output logic             o_RUN,
  output logic             o_BUSY,
  output logic             o_START_ERR,
  output logic [CNT_W-1:0] o_FRAMES_SENT,
  output logic [31:0]      o_STALL_CYCLES,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast
);
  localparam logic [1:0] IDLE = 2'd0, STREAM = 2'd1, GAP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, count_q, count_d, frames_q, frames_d, cell_q, cell_d;
  logic [GAP_W-1:0] gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic stop_pend_q, stop_pend_d, err_q, err_d, run_q, run_d;
  logic start, stop, streaming, beat, last, accept, done;
  logic [CNT_W-1:0] frames_inc;
  assign start = i_START & i_START_wstrobe;
  assign stop = i_STOP & i_STOP_wstrobe;
  assign streaming = state_q == STREAM;
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tvalid = s_axis_tvalid & streaming;
  assign s_axis_tready = m_axis_tready & streaming;
  assign beat = m_axis_tvalid & m_axis_tready;
  assign last = streaming & (cell_q == len_q - CNT_W'(1));
  assign m_axis_tlast = last;
  assign accept = (state_q == IDLE) & start & ~stop & (i_FRAME_LEN != '0) & (i_FIFO_COUNT != '0);
  assign frames_inc = &frames_q ? frames_q : frames_q + CNT_W'(1);
  // a stop arriving on the tlast beat itself still ends after that frame
  assign done = stop_pend_q | stop | ((count_q != '0) & (frames_inc == count_q));
  assign o_RUN = run_q;
  assign o_BUSY = state_q != IDLE;
  assign o_START_ERR = err_q;
  assign o_FRAMES_SENT = frames_q;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    count_d = count_q;
    gap_d = gap_q;
    frames_d = frames_q;
    cell_d = cell_q;
    gap_cnt_d = gap_cnt_q;
    stop_pend_d = stop_pend_q;
    err_d = start & ~stop & ~accept;
    if (accept) begin
      state_d = STREAM;
      len_d = i_FRAME_LEN;
      count_d = i_FRAME_COUNT;
      gap_d = i_GAP_CYCLES;
      frames_d = '0;
      cell_d = '0;
      gap_cnt_d = '0;
      stop_pend_d = 1'b0;
    end else if (streaming) begin
      stop_pend_d = stop_pend_q | stop;
      if (beat) cell_d = last ? '0 : cell_q + CNT_W'(1);
      if (beat & last) begin
        frames_d = frames_inc;
        gap_cnt_d = '0;
        state_d = done ? IDLE : (gap_q != '0) ? GAP : STREAM;
      end
    end else if (state_q == GAP) begin
      gap_cnt_d = gap_cnt_q + GAP_W'(1);
      state_d = stop ? IDLE : (gap_cnt_q == gap_q - GAP_W'(1)) ? STREAM : GAP;
    end
    run_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      count_q <= '0;
      gap_q <= '0;
      frames_q <= '0;
      cell_q <= '0;
      gap_cnt_q <= '0;
      stop_pend_q <= 1'b0;
      err_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      count_q <= count_d;
      gap_q <= gap_d;
      frames_q <= frames_d;
      cell_q <= cell_d;
      gap_cnt_q <= gap_cnt_d;
      stop_pend_q <= stop_pend_d;
      err_q <= err_d;
      run_q <= run_d;
    end
  end
`ifdef SENSOR_INJECT_SCHED_STALL_EN
  logic [31:0] stall_q, stall_d;
  always_comb stall_d = accept ? '0 : (streaming & s_axis_tvalid & ~m_axis_tready & ~&stall_q) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign o_STALL_CYCLES = stall_q;
`else
  assign o_STALL_CYCLES = '0;
`endif
endmodule
